// File: rtl/ks_voice_scheduler_if.sv
// Note-request channel from the key/sequencer source into the voice scheduler.
// Handshake: a note transfers on a rising clk edge where note_valid and note_ready are both 1;
// the source holds note_tone/note_cutoff stable while note_valid is high and not yet accepted.
interface ks_voice_scheduler_if #(
    parameter int TONE_W = 12,
    parameter int CUT_W  = 3
);
    logic              note_valid;
    logic              note_ready;
    logic [TONE_W-1:0] note_tone;
    logic [CUT_W-1:0]  note_cutoff;

    modport master (
        output note_valid,
        output note_tone,
        output note_cutoff,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_tone,
        input  note_cutoff,
        output note_ready
    );
endinterface

// File: rtl/ks_voice_scheduler.sv
// Polyphony controller: allocates note requests to Karplus-Strong voices (oldest-steal),
// and generates the shared sample strobe, paused while the audio FIFO is full.
module ks_voice_scheduler #(
    parameter int NVOICES       = 4,
    parameter int TONE_W        = 12,
    parameter int CUT_W         = 3,
    parameter int TICK_DIV      = 4,
    parameter int DECAY_SAMPLES = 24000
) (
    input  logic                      clk,
    input  logic                      aclr,
    ks_voice_scheduler_if.slave       note,
    input  logic                      fifo_full,
    output logic                      clk_sample,
    output logic [NVOICES-1:0]        voice_trigger,
    output logic [NVOICES*TONE_W-1:0] voice_tone,
    output logic [NVOICES*CUT_W-1:0]  voice_cutoff,
    output logic [NVOICES-1:0]        voice_busy,
    output logic                      steal,
    output logic [1:0]                fsm_state
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int VIDX_W = $clog2(NVOICES);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [15:0]       AGE_MAX  = 16'(DECAY_SAMPLES);
    localparam logic [TONE_W-1:0] TONE_RST = TONE_W'(699);
    localparam logic [CUT_W-1:0]  CUT_RST  = CUT_W'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_TRIG  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [CNT_W-1:0]    tick_cnt;
    logic [15:0]         age    [NVOICES];
    logic [TONE_W-1:0]   tone_r [NVOICES];
    logic [CUT_W-1:0]    cut_r  [NVOICES];

    logic [TONE_W-1:0]   lat_tone;
    logic [CUT_W-1:0]    lat_cut;
    logic [VIDX_W-1:0]   sel_v;

    logic                note_accept;
    logic                do_alloc;
    logic                do_fire;

    logic                any_free;
    logic [VIDX_W-1:0]   free_idx;
    logic [VIDX_W-1:0]   old_idx;
    logic [15:0]         old_age;
    logic [VIDX_W-1:0]   alloc_idx;

    // Sample strobe: counter only moves while the FIFO can take a sample,
    // so a stall resumes from wherever the period was interrupted.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            tick_cnt   <= '0;
            clk_sample <= 1'b0;
        end else if (fifo_full) begin
            clk_sample <= 1'b0;
        end else if (tick_cnt == CNT_LAST) begin
            tick_cnt   <= '0;
            clk_sample <= 1'b1;
        end else begin
            tick_cnt   <= tick_cnt + 1'b1;
            clk_sample <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NVOICES; i++) begin
            voice_busy[i] = (age[i] < AGE_MAX);
        end
    end

    // Voice choice: lowest free index, otherwise the oldest voice (ties to lowest index).
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        old_age  = age[0];
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (!voice_busy[i]) begin
                any_free = 1'b1;
                free_idx = VIDX_W'(i);
            end
        end
        for (int i = 1; i < NVOICES; i++) begin
            if (age[i] > old_age) begin
                old_age = age[i];
                old_idx = VIDX_W'(i);
            end
        end
        alloc_idx = any_free ? free_idx : old_idx;
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        note_accept = 1'b0;
        do_alloc    = 1'b0;
        do_fire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (note.note_valid) begin
                    note_accept = 1'b1;
                    state_nxt   = S_ALLOC;
                end
            end
            S_ALLOC: begin
                do_alloc  = 1'b1;
                state_nxt = S_TRIG;
            end
            S_TRIG: begin
                if (clk_sample) begin
                    do_fire   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign note.note_ready = (state == S_IDLE);
    assign steal           = do_alloc & ~any_free;
    assign fsm_state       = state;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            lat_tone <= '0;
            lat_cut  <= '0;
        end else if (note_accept) begin
            lat_tone <= note.note_tone;
            lat_cut  <= note.note_cutoff;
        end
    end

    // Only the selected voice's registers are written; the rest hold through an allocation.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sel_v         <= '0;
            voice_trigger <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                tone_r[i] <= TONE_RST;
                cut_r[i]  <= CUT_RST;
            end
        end else begin
            if (do_alloc) begin
                sel_v             <= alloc_idx;
                tone_r[alloc_idx] <= lat_tone;
                cut_r[alloc_idx]  <= lat_cut;
                voice_trigger     <= NVOICES'(1) << alloc_idx;
            end
            if (do_fire) begin
                voice_trigger <= '0;
            end
        end
    end

    // Retrigger zeroes the age and wins over the coincident strobe increment.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < NVOICES; i++) begin
                age[i] <= AGE_MAX;
            end
        end else begin
            for (int i = 0; i < NVOICES; i++) begin
                if (do_fire && (sel_v == VIDX_W'(i))) begin
                    age[i] <= 16'd0;
                end else if (clk_sample && (age[i] < AGE_MAX)) begin
                    age[i] <= age[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NVOICES; g++) begin : g_pack
        assign voice_tone[g*TONE_W +: TONE_W] = tone_r[g];
        assign voice_cutoff[g*CUT_W +: CUT_W] = cut_r[g];
    end

endmodule
